// File: rtl/hazard_stall_control.sv
// Pipeline interlock: load-use stall detection plus the mult/div handshake FSM.
// Owns PC/FD/DX hold and bubble controls for hazards the bypass network cannot cover.
module hazard_stall_control #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_fd_ir,
  input  logic [31:0] i_dx_ir,
  input  logic        i_branch_flush,
  input  logic        i_md_result_rdy,
  output logic        o_pc_stall,
  output logic        o_fd_stall,
  output logic        o_dx_stall,
  output logic        o_dx_bubble,
  output logic        o_xm_bubble,
  output logic        o_ctrl_mult,
  output logic        o_ctrl_div,
  output logic        o_md_result_we,
  output logic        o_md_busy,
  output logic        o_md_timeout
);

  localparam int CW = $clog2(MD_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BUSY = CW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_is_mul;
  logic          r_timeout;
  logic          r_armed;

  logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
  logic [4:0] w_dx_op, w_dx_rd, w_dx_aluop;
  logic [4:0] w_src_a, w_src_b;
  logic       w_use_a, w_use_b;
  logic       w_is_md, w_is_lw, w_load_use, w_idle_md, w_hold;
  logic       w_unused;

  assign w_fd_op    = i_fd_ir[31:27];
  assign w_fd_rd    = i_fd_ir[26:22];
  assign w_fd_rs    = i_fd_ir[21:17];
  assign w_fd_rt    = i_fd_ir[16:12];
  assign w_dx_op    = i_dx_ir[31:27];
  assign w_dx_rd    = i_dx_ir[26:22];
  assign w_dx_aluop = i_dx_ir[6:2];
  assign w_unused   = ^{i_fd_ir[11:0], i_dx_ir[21:7], i_dx_ir[1:0]};

  // Source registers the FD instruction reads in decode; sw data is forwarded later.
  always_comb begin
    w_src_a = 5'd0;
    w_src_b = 5'd0;
    w_use_a = 1'b0;
    w_use_b = 1'b0;
    case (w_fd_op)
      5'b00000: begin
        w_src_a = w_fd_rs; w_use_a = 1'b1;
        w_src_b = w_fd_rt; w_use_b = 1'b1;
      end
      5'b00101, 5'b01000, 5'b00111: begin
        w_src_a = w_fd_rs; w_use_a = 1'b1;
      end
      5'b00010, 5'b00110: begin
        w_src_a = w_fd_rd; w_use_a = 1'b1;
        w_src_b = w_fd_rs; w_use_b = 1'b1;
      end
      5'b00100: begin
        w_src_a = w_fd_rd; w_use_a = 1'b1;
      end
      5'b10110: begin
        w_src_a = 5'd30; w_use_a = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_is_md = (w_dx_op == 5'b00000) &&
                   ((w_dx_aluop == 5'b00110) || (w_dx_aluop == 5'b00111));
  assign w_is_lw = (w_dx_op == 5'b01000) && (w_dx_rd != 5'd0);

  assign w_load_use = i_rst_n && (r_state == S_IDLE) && w_is_lw && !i_branch_flush &&
                      ((w_use_a && (w_src_a == w_dx_rd)) || (w_use_b && (w_src_b == w_dx_rd)));
  assign w_idle_md  = i_rst_n && (r_state == S_IDLE) && w_is_md;
  assign w_hold     = (r_state == S_START) || (r_state == S_BUSY);

  // r_armed keeps the first edge after reset release from launching a start pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_is_mul  <= 1'b0;
      r_timeout <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_is_md && r_armed) begin
            r_state  <= S_START;
            r_is_mul <= (w_dx_aluop == 5'b00110);
          end
        end
        S_START: begin
          r_count <= '0;
          r_state <= i_md_result_rdy ? S_DONE : S_BUSY;
        end
        S_BUSY: begin
          if (i_md_result_rdy) begin
            r_state <= S_DONE;
          end else if (r_count == LAST_BUSY) begin
            r_state   <= S_DONE;
            r_timeout <= 1'b1;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_pc_stall     = w_idle_md | w_hold | w_load_use;
  assign o_fd_stall     = w_idle_md | w_hold | w_load_use;
  assign o_dx_stall     = w_idle_md | w_hold;
  assign o_dx_bubble    = w_load_use;
  assign o_xm_bubble    = w_idle_md | w_hold;
  assign o_ctrl_mult    = (r_state == S_START) && r_is_mul;
  assign o_ctrl_div     = (r_state == S_START) && !r_is_mul;
  assign o_md_result_we = (r_state == S_DONE);
  assign o_md_busy      = (r_state != S_IDLE);
  assign o_md_timeout   = r_timeout;

endmodule

// File: tb/tb_hazard_stall_control.sv
// Directed bench for hazard_stall_control: every-cycle model comparison plus
// hand-computed literal checks on pulse widths and stall durations.
module tb_hazard_stall_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] fdIr = 32'd0;
  logic [31:0] dxIr = 32'd0;
  logic        flush = 1'b0;
  logic        rdy = 1'b0;
  logic pcStall, fdStall, dxStall, dxBubble, xmBubble;
  logic ctrlMult, ctrlDiv, resultWe, mdBusy, mdTimeout;

  int errors = 0;
  int checks = 0;
  int cntPc = 0, cntDxB = 0, cntMult = 0, cntDiv = 0, cntWe = 0, cntBusy = 0;

  // Reference model state: 0 idle, 1 start, 2 busy, 3 done
  int mPhase = 0;
  int mBusyN = 0;
  bit mIsMul = 1'b0;
  bit mTimeout = 1'b0;
  bit mArmed = 1'b0;

  always #5 clk = ~clk;

  hazard_stall_control #(.MD_TIMEOUT(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fd_ir(fdIr), .i_dx_ir(dxIr),
    .i_branch_flush(flush), .i_md_result_rdy(rdy),
    .o_pc_stall(pcStall), .o_fd_stall(fdStall), .o_dx_stall(dxStall),
    .o_dx_bubble(dxBubble), .o_xm_bubble(xmBubble), .o_ctrl_mult(ctrlMult),
    .o_ctrl_div(ctrlDiv), .o_md_result_we(resultWe), .o_md_busy(mdBusy),
    .o_md_timeout(mdTimeout)
  );

  function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                     input int rt, input int aluop);
    logic [31:0] v;
    v = {op[4:0], rd[4:0], rs[4:0], rt[4:0], 5'd0, aluop[4:0], 2'b00};
    return v;
  endfunction

  function automatic bit isMd(input logic [31:0] ir);
    return ir[31:27] == 5'd0 && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
  endfunction

  function automatic bit reads(input logic [31:0] ir, input logic [4:0] r);
    int op;
    op = int'(ir[31:27]);
    if (r == 5'd0) return 1'b0;
    if (op == 0) return r == ir[21:17] || r == ir[16:12];
    if (op == 5 || op == 8 || op == 7) return r == ir[21:17];
    if (op == 2 || op == 6) return r == ir[26:22] || r == ir[21:17];
    if (op == 4) return r == ir[26:22];
    if (op == 22) return r == 5'd30;
    return 1'b0;
  endfunction

  function automatic logic [9:0] expVec();
    bit lu, md, hold;
    if (!rst_n) return 10'd0;
    md = (mPhase == 0) && isMd(dxIr);
    lu = (mPhase == 0) && dxIr[31:27] == 5'd8 && reads(fdIr, dxIr[26:22]) && !flush;
    hold = (mPhase == 1) || (mPhase == 2);
    return {md | hold | lu, md | hold | lu, md | hold, lu, md | hold,
            mPhase == 1 && mIsMul, mPhase == 1 && !mIsMul, mPhase == 3,
            mPhase != 0, mTimeout};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase <= 0; mBusyN <= 0; mTimeout <= 1'b0; mArmed <= 1'b0;
    end else begin
      mArmed <= 1'b1;
      if (mPhase == 0 && mArmed && isMd(dxIr)) begin
        mPhase <= 1;
        mIsMul <= dxIr[6:2] == 5'd6;
      end else if (mPhase == 1) begin
        mBusyN <= 0;
        mPhase <= rdy ? 3 : 2;
      end else if (mPhase == 2) begin
        mBusyN <= mBusyN + 1;
        if (rdy) mPhase <= 3;
        else if (mBusyN + 1 == 64) begin
          mPhase <= 3; mTimeout <= 1'b1;
        end
      end else if (mPhase == 3) begin
        mPhase <= 0;
      end
    end
  end

  // Mid-cycle comparison against the model, plus event counters for literal checks
  always @(negedge clk) begin
    logic [9:0] act, expv;
    act = {pcStall, fdStall, dxStall, dxBubble, xmBubble, ctrlMult, ctrlDiv,
           resultWe, mdBusy, mdTimeout};
    expv = expVec();
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL outputs t=%0t got=%b want=%b", $time, act, expv);
    end
    if (rst_n) begin
      cntPc += int'(pcStall); cntDxB += int'(dxBubble); cntMult += int'(ctrlMult);
      cntDiv += int'(ctrlDiv); cntWe += int'(resultWe); cntBusy += int'(mdBusy);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] fd, input logic [31:0] dx,
                               input logic fl, input logic rd);
    @(posedge clk);
    #1;
    fdIr = fd; dxIr = dx; flush = fl; rdy = rd;
  endtask

  task automatic clearCounts();
    cntPc = 0; cntDxB = 0; cntMult = 0; cntDiv = 0; cntWe = 0; cntBusy = 0;
  endtask

  // IDLE, START, busyN BUSY cycles (rdy on the last one if rdyAt>0), DONE, then nops
  task automatic runMd(input logic [31:0] ir, input int rdyAt);
    int busyN;
    busyN = (rdyAt > 0) ? rdyAt : 64;
    applyStimulus(32'd0, ir, 1'b0, 1'b0);
    applyStimulus(32'd0, ir, 1'b0, 1'b0);
    for (int k = 1; k <= busyN; k++) applyStimulus(32'd0, ir, 1'b0, k == rdyAt);
    applyStimulus(32'd0, ir, 1'b0, 1'b0);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [31:0] fd;
    logic [31:0] dx;
    logic        fl;
    int          stall;
  } luVec_t;

  initial begin
    luVec_t tab[$];
    logic [31:0] lwR5, addDep, mulIr, divIr;
    lwR5   = mk(8, 5, 2, 0, 0);
    addDep = mk(0, 3, 5, 2, 0);
    mulIr  = mk(0, 4, 1, 2, 6);
    divIr  = mk(0, 4, 1, 2, 7);

    #1 rst_n = 1'b0;
    #1 checkOutput("reset_outputs", int'({pcStall, fdStall, dxStall, dxBubble, xmBubble,
                   ctrlMult, ctrlDiv, resultWe, mdBusy, mdTimeout}), 0);
    #21 rst_n = 1'b1;
    repeat (2) applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);

    // Load-use stall lasts one cycle once the bubble reaches DX
    clearCounts();
    applyStimulus(addDep, lwR5, 1'b0, 1'b0);
    #1 checkOutput("lu_pc_stall", int'(pcStall), 1);
    checkOutput("lu_dx_bubble", int'(dxBubble), 1);
    applyStimulus(addDep, 32'd0, 1'b0, 1'b0);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("lu_stall_cycles", cntPc, 1);
    checkOutput("lu_bubble_cycles", cntDxB, 1);

    tab = '{
      '{mk(7, 5, 4, 0, 0),  lwR5, 1'b0, 0},
      '{mk(7, 4, 5, 0, 0),  lwR5, 1'b0, 1},
      '{mk(0, 3, 0, 0, 0),  mk(8, 0, 2, 0, 0), 1'b0, 0},
      '{addDep,             lwR5, 1'b1, 0},
      '{mk(2, 5, 1, 0, 0),  lwR5, 1'b0, 1},
      '{mk(6, 1, 5, 0, 0),  lwR5, 1'b0, 1},
      '{mk(4, 5, 0, 0, 0),  lwR5, 1'b0, 1},
      '{mk(5, 1, 5, 0, 0),  lwR5, 1'b0, 1},
      '{mk(0, 3, 1, 5, 0),  lwR5, 1'b0, 1},
      '{mk(0, 3, 1, 2, 0),  lwR5, 1'b0, 0},
      '{mk(22, 0, 0, 0, 0), mk(8, 30, 1, 0, 0), 1'b0, 1},
      '{mk(1, 5, 5, 5, 0),  lwR5, 1'b0, 0},
      '{mk(8, 3, 5, 0, 0),  lwR5, 1'b0, 1}
    };
    foreach (tab[i]) begin
      applyStimulus(tab[i].fd, tab[i].dx, tab[i].fl, 1'b0);
      #1 checkOutput($sformatf("lu_table_%0d", i), int'(pcStall), tab[i].stall);
    end
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);

    // Multiply finishing on the 17th busy cycle
    clearCounts();
    runMd(mulIr, 17);
    checkOutput("mul_start_pulses", cntMult, 1);
    checkOutput("mul_div_pulses", cntDiv, 0);
    checkOutput("mul_we_pulses", cntWe, 1);
    checkOutput("mul_stall_cycles", cntPc, 19);
    checkOutput("mul_busy_cycles", cntBusy, 19);
    checkOutput("mul_no_timeout", int'(mdTimeout), 0);

    // Divide that never answers: forced completion after 64 busy cycles
    clearCounts();
    runMd(divIr, 0);
    checkOutput("div_start_pulses", cntDiv, 1);
    checkOutput("div_we_pulses", cntWe, 1);
    checkOutput("div_stall_cycles", cntPc, 66);
    checkOutput("div_busy_cycles", cntBusy, 66);
    repeat (5) applyStimulus(32'd0, 32'd0, 1'b0, 1'b1);
    checkOutput("timeout_sticky", int'(mdTimeout), 1);

    // Reset mid-operation, rdy high throughout, dx still holding the multiply
    applyStimulus(32'd0, mulIr, 1'b0, 1'b0);
    repeat (4) applyStimulus(32'd0, mulIr, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0; rdy = 1'b1;
    #1 checkOutput("reset_mid_busy", int'({pcStall, fdStall, dxStall, dxBubble, xmBubble,
                   ctrlMult, ctrlDiv, resultWe, mdBusy, mdTimeout}), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    clearCounts();
    @(posedge clk);
    #1 checkOutput("no_pulse_first_edge", int'(ctrlMult), 0);
    checkOutput("idle_first_edge", int'(mdBusy), 0);
    @(posedge clk);
    #1 checkOutput("pulse_second_edge", int'(ctrlMult), 1);
    @(posedge clk);
    #1 checkOutput("rdy_in_start_done", int'(resultWe), 1);
    dxIr = 32'd0; rdy = 1'b0;
    repeat (3) applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("post_reset_pulses", cntMult, 1);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
